// File: rtl/div_ctrl.sv
// Sequencing controller for the integer divide unit: radix-2 restoring
// shift-subtract over WIDTH iterations, with signed fixup, divide-by-zero and abort.
module div_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rem;
    logic             sign_q;
    logic             sign_r;

    // The shifted remainder keeps its carry-out bit so divisors with the MSB set still work.
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rem_d;

    assign shifted = {rem, q[WIDTH-1]};
    assign fits    = shifted[WIDTH] | (shifted[WIDTH-1:0] >= dmag);
    assign diff    = shifted[WIDTH-1:0] - dmag;
    assign rem_d   = fits ? diff : shifted[WIDTH-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state logic; abort wins over everything, including a start in IDLE
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (start && !abort) state_d = (divisor == '0) ? DONE : ITER;
            ITER:  if (abort) state_d = IDLE;
                   else if (cnt == CW'(WIDTH - 1)) state_d = FIXUP;
            FIXUP: state_d = abort ? IDLE : DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            dmag        <= '0;
            q           <= '0;
            rem         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    if (divisor == '0) begin
                        div_by_zero <= 1'b1;
                        hi          <= dividend;
                        lo          <= '1;
                    end else begin
                        div_by_zero <= 1'b0;
                        dmag   <= (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
                        q      <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                        rem    <= '0;
                        cnt    <= '0;
                        sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r <= is_signed & dividend[WIDTH-1];
                    end
                end
                ITER: if (!abort) begin
                    rem <= rem_d;
                    q   <= {q[WIDTH-2:0], fits};
                    cnt <= cnt + CW'(1);
                end
                FIXUP: if (!abort) begin
                    lo <= sign_q ? -q : q;
                    hi <= sign_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: cycle-accurate latency, signed fixup,
// divide-by-zero, ignored restart, abort and mid-operation reset.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        abort;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int done_cyc;
    int pulses;
    int busy_bad;

    div_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .abort(abort),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request in cycle 0, then watch cycles 1..39 for done/busy;
    // optional restart/abort/reset injections at given cycle numbers.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int restart_at, input int abort_at, input int rst_at);
        int cyc;
        logic exp_busy;
        is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
        tick();
        start = 1'b0;
        done_cyc = -1; pulses = 0; busy_bad = 0;
        for (cyc = 1; cyc < 40; cyc++) begin
            if (done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            exp_busy = ((done_cyc < 0) && (cyc <= abort_at) && (cyc <= rst_at)) || (cyc == done_cyc);
            if (busy !== exp_busy) busy_bad++;
            if (cyc == restart_at) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
            end else begin
                start = 1'b0;
            end
            abort = (cyc == abort_at);
            reset = (cyc == rst_at);
            tick();
        end
        abort = 1'b0; reset = 1'b0; start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_dbz",  32'(div_by_zero), 32'd0);
        chk("reset_hi",   hi, 32'd0);
        chk("reset_lo",   lo, 32'd0);

        run_div(1'b0, 32'd100, 32'd7, -1, 1000, 1000);
        chk("u100_7_done_cyc", 32'(done_cyc), 32'd34);
        chk("u100_7_pulses",   32'(pulses), 32'd1);
        chk("u100_7_busy",     32'(busy_bad), 32'd0);
        chk("u100_7_lo",       lo, 32'd14);
        chk("u100_7_hi",       hi, 32'd2);
        chk("u100_7_dbz",      32'(div_by_zero), 32'd0);

        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1000, 1000);
        chk("s-7_2_lo", lo, 32'hFFFF_FFFD);
        chk("s-7_2_hi", hi, 32'hFFFF_FFFF);

        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, -1, 1000, 1000);
        chk("s7_-2_lo", lo, 32'hFFFF_FFFD);
        chk("s7_-2_hi", hi, 32'd1);

        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, -1, 1000, 1000);
        chk("umax_1_lo", lo, 32'hFFFF_FFFF);
        chk("umax_1_hi", hi, 32'd0);

        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1000, 1000);
        chk("smin_-1_lo",  lo, 32'h8000_0000);
        chk("smin_-1_hi",  hi, 32'd0);
        chk("smin_-1_dbz", 32'(div_by_zero), 32'd0);

        run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, -1, 1000, 1000);
        chk("ubig_lo", lo, 32'd1);
        chk("ubig_hi", hi, 32'h7FFF_FFFE);

        run_div(1'b0, 32'h1234, 32'd0, -1, 1000, 1000);
        chk("dbz_done_cyc", 32'(done_cyc), 32'd1);
        chk("dbz_pulses",   32'(pulses), 32'd1);
        chk("dbz_busy",     32'(busy_bad), 32'd0);
        chk("dbz_hi",       hi, 32'h1234);
        chk("dbz_lo",       lo, 32'hFFFF_FFFF);
        chk("dbz_flag",     32'(div_by_zero), 32'd1);

        run_div(1'b0, 32'd1000, 32'd10, -1, 1000, 1000);
        chk("dbz_clear_flag", 32'(div_by_zero), 32'd0);
        chk("dbz_clear_lo",   lo, 32'd100);
        chk("dbz_clear_hi",   hi, 32'd0);

        run_div(1'b0, 32'd50, 32'd6, 10, 1000, 1000);
        chk("restart_done_cyc", 32'(done_cyc), 32'd34);
        chk("restart_pulses",   32'(pulses), 32'd1);
        chk("restart_lo",       lo, 32'd8);
        chk("restart_hi",       hi, 32'd2);

        run_div(1'b0, 32'd77, 32'd5, -1, 15, 1000);
        chk("abort_pulses", 32'(pulses), 32'd0);
        chk("abort_busy",   32'(busy_bad), 32'd0);
        chk("abort_lo",     lo, 32'd8);
        chk("abort_hi",     hi, 32'd2);
        chk("abort_dbz",    32'(div_by_zero), 32'd0);

        run_div(1'b0, 32'd100, 32'd7, -1, 1000, 20);
        chk("rst_pulses", 32'(pulses), 32'd0);
        chk("rst_busy",   32'(busy_bad), 32'd0);
        chk("rst_lo",     lo, 32'd0);
        chk("rst_hi",     hi, 32'd0);
        chk("rst_dbz",    32'(div_by_zero), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
